// File: rtl/clk_div_ratio_ctrl_pkg.sv
// Shared definitions for the clock-divider configuration sequencer.
// State encodings are plain constants so older blocks can reuse them.
package clk_div_ratio_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MIN_DIV_RATIO = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_RUN       = 3'd1;
    localparam state_t ST_WAIT_EDGE = 3'd2;
    localparam state_t ST_GATE      = 3'd3;
    localparam state_t ST_SETTLE    = 3'd4;

endpackage

// File: rtl/clk_div_ratio_ctrl_mirror.sv
// Cycle-exact copy of the divider's period counter.
// Flags the last cycle of a divided period, where ratio changes are safe.
module div_period_mirror
    import clk_div_ratio_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] div_ratio,
    output logic             boundary
);

    logic [WIDTH-1:0] cnt;
    logic             counting;
    logic             at_last;

    // Ratios 0/1 bypass the divider, so there is no period to track.
    assign counting = clk_en && (div_ratio >= WIDTH'(MIN_DIV_RATIO));
    assign at_last  = (cnt == div_ratio - WIDTH'(1));
    assign boundary = at_last || !counting;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (!counting || at_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Sequences enable/ratio updates into the clock divider so that changes
// land only at a period boundary while the divided clock is low.
module clk_div_ratio_ctrl
    import clk_div_ratio_ctrl_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int DEFAULT_RATIO = 2,
    parameter int SETTLE_CYC    = 2
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_req_valid,
    input  logic [WIDTH-1:0] i_req_ratio,
    output logic             o_req_ready,
    output logic [WIDTH-1:0] o_div_ratio,
    output logic             o_clk_en,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    // Handshake: a request transfers on any cycle where i_req_valid and
    // o_req_ready are both high; the requester holds valid/ratio until then.
    state_t           state, state_n;
    logic [WIDTH-1:0] ratio_n;
    logic             clk_en_n;
    logic             done_n;
    logic [WIDTH-1:0] shadow, shadow_n;
    logic             pend, pend_n;
    logic             stop, stop_n;
    logic [3:0]       settle, settle_n;
    logic             accept;
    logic             boundary;

    assign accept = i_req_valid && o_req_ready;

    div_period_mirror #(
        .WIDTH(WIDTH)
    ) u_mirror (
        .i_ref_clk(i_ref_clk),
        .i_rst_n  (i_rst_n),
        .clk_en   (o_clk_en),
        .div_ratio(o_div_ratio),
        .boundary (boundary)
    );

    always_comb begin
        state_n  = state;
        ratio_n  = o_div_ratio;
        clk_en_n = o_clk_en;
        done_n   = 1'b0;
        shadow_n = shadow;
        pend_n   = pend;
        stop_n   = stop;
        settle_n = settle;
        case (state)
            ST_IDLE: begin
                // A ratio write wins over enable; RUN follows next cycle.
                if (accept) begin
                    ratio_n = i_req_ratio;
                    done_n  = 1'b1;
                end else if (i_enable) begin
                    clk_en_n = 1'b1;
                    state_n  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    shadow_n = i_req_ratio;
                    pend_n   = 1'b1;
                    stop_n   = !i_enable;
                    state_n  = ST_WAIT_EDGE;
                end else if (!i_enable) begin
                    stop_n  = 1'b1;
                    state_n = ST_WAIT_EDGE;
                end
            end
            ST_WAIT_EDGE: begin
                if (!i_enable) begin
                    stop_n = 1'b1;
                end
                if (boundary) begin
                    clk_en_n = 1'b0;
                    state_n  = ST_GATE;
                end
            end
            ST_GATE: begin
                if (pend) begin
                    ratio_n = shadow;
                end
                settle_n = SETTLE_LOAD;
                state_n  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle == 4'd0) begin
                    done_n = pend;
                    pend_n = 1'b0;
                    if (stop) begin
                        stop_n  = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        clk_en_n = 1'b1;
                        state_n  = ST_RUN;
                    end
                end else begin
                    settle_n = settle - 4'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            o_div_ratio <= WIDTH'(DEFAULT_RATIO);
            o_clk_en    <= 1'b0;
            o_done      <= 1'b0;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
            shadow      <= '0;
            pend        <= 1'b0;
            stop        <= 1'b0;
            settle      <= 4'd0;
        end else begin
            state       <= state_n;
            o_div_ratio <= ratio_n;
            o_clk_en    <= clk_en_n;
            o_done      <= done_n;
            o_req_ready <= (state_n == ST_IDLE) || (state_n == ST_RUN);
            o_busy      <= (state_n == ST_WAIT_EDGE) || (state_n == ST_GATE) ||
                           (state_n == ST_SETTLE);
            shadow      <= shadow_n;
            pend        <= pend_n;
            stop        <= stop_n;
            settle      <= settle_n;
        end
    end

endmodule
